// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master data-memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam int CNT_W        = 3;
    localparam int READ_LAT_MAX = 7;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both master request ports plus the shared memory bus.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              iCpuReq;
    logic              iCpuWE;
    logic [ADDR_W-1:0] iCpuAddr;
    logic [DATA_W-1:0] iCpuWData;
    logic [BE_W-1:0]   iCpuBE;
    logic              oCpuAck;
    logic [DATA_W-1:0] oCpuRData;

    logic              iAuxReq;
    logic              iAuxWE;
    logic [ADDR_W-1:0] iAuxAddr;
    logic [DATA_W-1:0] iAuxWData;
    logic [BE_W-1:0]   iAuxBE;
    logic              oAuxAck;
    logic [DATA_W-1:0] oAuxRData;

    logic [ADDR_W-1:0] oAddress;
    logic [DATA_W-1:0] oWriteData;
    logic              oWriteEnable;
    logic              oReadEnable;
    logic [BE_W-1:0]   oByteEnable;
    logic [DATA_W-1:0] iReadData;
    logic [1:0]        oGrant;

    modport slave (
        input  iCpuReq, iCpuWE, iCpuAddr, iCpuWData, iCpuBE,
        input  iAuxReq, iAuxWE, iAuxAddr, iAuxWData, iAuxBE,
        input  iReadData,
        output oCpuAck, oCpuRData, oAuxAck, oAuxRData,
        output oAddress, oWriteData, oWriteEnable, oReadEnable, oByteEnable, oGrant
    );

    modport master (
        output iCpuReq, iCpuWE, iCpuAddr, iCpuWData, iCpuBE,
        output iAuxReq, iAuxWE, iAuxAddr, iAuxWData, iAuxBE,
        output iReadData,
        input  oCpuAck, oCpuRData, oAuxAck, oAuxRData,
        input  oAddress, oWriteData, oWriteEnable, oReadEnable, oByteEnable, oGrant
    );

endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// Two-request round-robin picker: a sole requester wins, a tie goes to the master not served last.
import mem_bus_arbiter_pkg::*;

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == M_AUX) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU and AUX accesses onto the single data-memory bus, one transfer at a time.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    mem_bus_arbiter_if.slave bus
);

    localparam int BE_W = DATA_W / 8;
    // Out-of-range latencies are clamped so the counter can never wrap.
    localparam int LAT_EFF = (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

    logic [1:0]        pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;

    rr_arbiter2 u_rr (
        .req   ({bus.iAuxReq, bus.iCpuReq}),
        .last  (last_q),
        .grant (pick)
    );

    always_comb begin
        if (owner_q == M_AUX) begin
            sel_we    = bus.iAuxWE;
            sel_addr  = bus.iAuxAddr;
            sel_wdata = bus.iAuxWData;
            sel_be    = bus.iAuxBE;
        end else begin
            sel_we    = bus.iCpuWE;
            sel_addr  = bus.iCpuAddr;
            sel_wdata = bus.iCpuWData;
            sel_be    = bus.iCpuBE;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            owner_q     <= M_CPU;
            last_q      <= M_AUX;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick != 2'b00) begin
                    owner_d = pick[1] ? M_AUX : M_CPU;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (sel_we) begin
                    state_d = S_DONE;
                end else if (cnt_q == LAT_LAST) begin
                    // Final read cycle: the bus data is valid now.
                    if (owner_q == M_AUX) aux_rdata_d = bus.iReadData;
                    else                  cpu_rdata_d = bus.iReadData;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.oAddress     = '0;
        bus.oWriteData   = '0;
        bus.oByteEnable  = '0;
        bus.oWriteEnable = 1'b0;
        bus.oReadEnable  = 1'b0;
        bus.oGrant       = 2'b00;
        bus.oCpuAck      = 1'b0;
        bus.oAuxAck      = 1'b0;
        case (state_q)
            S_ACCESS: begin
                bus.oAddress     = sel_addr;
                bus.oWriteData   = sel_wdata;
                bus.oByteEnable  = sel_be;
                bus.oWriteEnable = sel_we;
                bus.oReadEnable  = ~sel_we;
                bus.oGrant       = (owner_q == M_AUX) ? 2'b10 : 2'b01;
            end
            S_DONE: begin
                bus.oCpuAck = (owner_q == M_CPU);
                bus.oAuxAck = (owner_q == M_AUX);
            end
            default: ;
        endcase
    end

    assign bus.oCpuRData = cpu_rdata_q;
    assign bus.oAuxRData = aux_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: READ_LAT=1 main instance plus READ_LAT=0/7 builds.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b7 ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) u_dut (.iCLK(clk), .iRST(rst), .bus(b1));
    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(0)) u_lat0 (.iCLK(clk), .iRST(rst), .bus(b0));
    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(7)) u_lat7 (.iCLK(clk), .iRST(rst), .bus(b7));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h1001_0000) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_A5A5);
    endfunction

    // Memory model: data is only valid in the READ_LAT-th cycle of a read strobe run.
    logic [3:0] run1 = '0, run0 = '0, run7 = '0;
    always_ff @(posedge clk) begin
        run1 <= b1.oReadEnable ? run1 + 4'd1 : 4'd0;
        run0 <= b0.oReadEnable ? run0 + 4'd1 : 4'd0;
        run7 <= b7.oReadEnable ? run7 + 4'd1 : 4'd0;
    end
    always_comb b1.iReadData = (b1.oReadEnable && run1 == 4'd1) ? mem_val(b1.oAddress) : 32'hBAD0_BAD0;
    always_comb b0.iReadData = (b0.oReadEnable && run0 == 4'd0) ? mem_val(b0.oAddress) : 32'hBAD0_BAD0;
    always_comb b7.iReadData = (b7.oReadEnable && run7 == 4'd7) ? mem_val(b7.oAddress) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for an Ack on the main instance; checks Ack exclusivity every cycle.
    task automatic wait_ack(output logic c_ack, output logic a_ack);
        c_ack = 1'b0;
        a_ack = 1'b0;
        for (int t = 0; t < 12; t++) begin
            step();
            check("ack_excl", 32'(b1.oCpuAck & b1.oAuxAck), 32'd0);
            if (b1.oCpuAck || b1.oAuxAck) begin
                c_ack = b1.oCpuAck;
                a_ack = b1.oAuxAck;
                return;
            end
        end
        check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_if();
        b1.iCpuReq = 0; b1.iCpuWE = 0; b1.iCpuAddr = '0; b1.iCpuWData = '0; b1.iCpuBE = '0;
        b1.iAuxReq = 0; b1.iAuxWE = 0; b1.iAuxAddr = '0; b1.iAuxWData = '0; b1.iAuxBE = '0;
        b0.iCpuReq = 0; b0.iCpuWE = 0; b0.iCpuAddr = '0; b0.iCpuWData = '0; b0.iCpuBE = '0;
        b0.iAuxReq = 0; b0.iAuxWE = 0; b0.iAuxAddr = '0; b0.iAuxWData = '0; b0.iAuxBE = '0;
        b7.iCpuReq = 0; b7.iCpuWE = 0; b7.iCpuAddr = '0; b7.iCpuWData = '0; b7.iCpuBE = '0;
        b7.iAuxReq = 0; b7.iAuxWE = 0; b7.iAuxAddr = '0; b7.iAuxWData = '0; b7.iAuxBE = '0;
    endtask

    initial begin
        logic c_ack, a_ack;
        int   c0, c7, re0, re7;

        clear_if();
        step();
        step();
        check("rst_grant", 32'(b1.oGrant), 32'd0);
        check("rst_we", 32'(b1.oWriteEnable), 32'd0);
        check("rst_re", 32'(b1.oReadEnable), 32'd0);
        check("rst_acks", 32'({b1.oCpuAck, b1.oAuxAck}), 32'd0);
        check("rst_cpu_rdata", b1.oCpuRData, 32'd0);
        check("rst_aux_rdata", b1.oAuxRData, 32'd0);
        rst = 1'b0;
        step();

        // Test 1: CPU read alone
        b1.iCpuWE = 0; b1.iCpuAddr = 32'h1001_0000; b1.iCpuBE = 4'hF; b1.iCpuReq = 1;
        step();
        check("t1_c1_re", 32'(b1.oReadEnable), 32'd1);
        check("t1_c1_grant", 32'(b1.oGrant), 32'd1);
        check("t1_c1_addr", b1.oAddress, 32'h1001_0000);
        check("t1_c1_we", 32'(b1.oWriteEnable), 32'd0);
        step();
        check("t1_c2_re", 32'(b1.oReadEnable), 32'd1);
        check("t1_c2_ack", 32'(b1.oCpuAck), 32'd0);
        step();
        check("t1_c3_ack", 32'(b1.oCpuAck), 32'd1);
        check("t1_c3_rdata", b1.oCpuRData, 32'hDEAD_BEEF);
        check("t1_c3_re", 32'(b1.oReadEnable), 32'd0);
        check("t1_c3_grant", 32'(b1.oGrant), 32'd0);
        b1.iCpuReq = 0;
        step();
        check("t1_c4_ack", 32'(b1.oCpuAck), 32'd0);
        check("t1_hold_rdata", b1.oCpuRData, 32'hDEAD_BEEF);

        // Test 2: AUX write
        b1.iAuxWE = 1; b1.iAuxAddr = 32'h1001_0004; b1.iAuxWData = 32'h1234_5678;
        b1.iAuxBE = 4'b0011; b1.iAuxReq = 1;
        step();
        check("t2_c1_we", 32'(b1.oWriteEnable), 32'd1);
        check("t2_c1_re", 32'(b1.oReadEnable), 32'd0);
        check("t2_c1_addr", b1.oAddress, 32'h1001_0004);
        check("t2_c1_wdata", b1.oWriteData, 32'h1234_5678);
        check("t2_c1_be", 32'(b1.oByteEnable), 32'h3);
        check("t2_c1_grant", 32'(b1.oGrant), 32'd2);
        step();
        check("t2_c2_we", 32'(b1.oWriteEnable), 32'd0);
        check("t2_c2_auxack", 32'(b1.oAuxAck), 32'd1);
        check("t2_c2_cpuack", 32'(b1.oCpuAck), 32'd0);
        b1.iAuxReq = 0;
        step();
        check("t2_aux_rdata", b1.oAuxRData, 32'd0);
        check("t2_cpu_rdata", b1.oCpuRData, 32'hDEAD_BEEF);

        // Test 3: continuous contention alternates CPU, AUX, CPU, AUX
        b1.iCpuWE = 0; b1.iCpuAddr = 32'h1001_0020; b1.iCpuReq = 1;
        b1.iAuxWE = 0; b1.iAuxAddr = 32'h1001_0040; b1.iAuxReq = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(c_ack, a_ack);
            check("t3_rr_cpu", 32'(c_ack), 32'((k % 2) == 0));
            check("t3_rr_aux", 32'(a_ack), 32'((k % 2) == 1));
            if (k == 3) begin
                b1.iCpuReq = 0;
                b1.iAuxReq = 0;
            end
        end
        check("t3_cpu_rdata", b1.oCpuRData, 32'hB5A4_A585);
        check("t3_aux_rdata", b1.oAuxRData, 32'hB5A4_A5E5);
        step();

        // Test 4: AUX request arrives in the middle of a CPU read
        b1.iCpuWE = 0; b1.iCpuAddr = 32'h1001_0000; b1.iCpuReq = 1;
        step();
        b1.iAuxWE = 1; b1.iAuxAddr = 32'h1001_0008; b1.iAuxWData = 32'hCAFE_F00D;
        b1.iAuxBE = 4'hF; b1.iAuxReq = 1;
        step();
        check("t4_c2_grant", 32'(b1.oGrant), 32'd1);
        check("t4_c2_addr", b1.oAddress, 32'h1001_0000);
        check("t4_c2_re", 32'(b1.oReadEnable), 32'd1);
        step();
        check("t4_c3_cpuack", 32'(b1.oCpuAck), 32'd1);
        check("t4_c3_auxack", 32'(b1.oAuxAck), 32'd0);
        check("t4_c3_rdata", b1.oCpuRData, 32'hDEAD_BEEF);
        b1.iCpuReq = 0;
        step();
        check("t4_c4_grant", 32'(b1.oGrant), 32'd0);
        step();
        check("t4_c5_grant", 32'(b1.oGrant), 32'd2);
        check("t4_c5_we", 32'(b1.oWriteEnable), 32'd1);
        check("t4_c5_wdata", b1.oWriteData, 32'hCAFE_F00D);
        step();
        check("t4_c6_auxack", 32'(b1.oAuxAck), 32'd1);
        b1.iAuxReq = 0;
        step();

        // Test 5: reset pulse during a write access
        b1.iCpuWE = 1; b1.iCpuAddr = 32'h1001_000C; b1.iCpuWData = 32'h0BAD_F00D; b1.iCpuReq = 1;
        step();
        check("t5_c1_we", 32'(b1.oWriteEnable), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_we", 32'(b1.oWriteEnable), 32'd0);
        check("t5_rst_grant", 32'(b1.oGrant), 32'd0);
        step();
        check("t5_rst_ack", 32'(b1.oCpuAck), 32'd0);
        rst = 1'b0;
        step();
        check("t5_re_we", 32'(b1.oWriteEnable), 32'd1);
        check("t5_re_grant", 32'(b1.oGrant), 32'd1);
        step();
        check("t5_re_ack", 32'(b1.oCpuAck), 32'd1);
        b1.iCpuReq = 0;
        step();

        // Test 6: READ_LAT=0 and READ_LAT=7 builds
        b0.iCpuWE = 0; b0.iCpuAddr = 32'h1001_0000; b0.iCpuBE = 4'hF; b0.iCpuReq = 1;
        b7.iCpuWE = 0; b7.iCpuAddr = 32'h1001_0010; b7.iCpuBE = 4'hF; b7.iCpuReq = 1;
        c0 = 0; c7 = 0; re0 = 0; re7 = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (b0.oReadEnable) re0++;
            if (b7.oReadEnable) re7++;
            if (b0.oCpuAck && c0 == 0) begin c0 = c; b0.iCpuReq = 0; end
            if (b7.oCpuAck && c7 == 0) begin c7 = c; b7.iCpuReq = 0; end
        end
        check("t6_lat0_ackcyc", 32'(c0), 32'd2);
        check("t6_lat7_ackcyc", 32'(c7), 32'd9);
        check("t6_lat0_recnt", 32'(re0), 32'd1);
        check("t6_lat7_recnt", 32'(re7), 32'd8);
        check("t6_lat0_rdata", b0.oCpuRData, 32'hDEAD_BEEF);
        check("t6_lat7_rdata", b7.oCpuRData, 32'hB5A4_A5B5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
